// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants for the keyboard path.
// ASCII codes of interest and default FIFO sizing.
package kbd_pkg;
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_CR  = 8'h0d;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/kbd_fifo_mem.sv
// kbd_fifo_mem: DEPTH x 8 register file.
// One synchronous write port, one asynchronous read port.
module kbd_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/kbd_fifo.sv
// kbd_fifo: keystroke FIFO between the PS/2 receiver
// and display consumers, with overflow flag and counter.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 3,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [7:0]       in_ascii,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [AW:0]      level,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] key_count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    rdata;
  logic          push_req;
  logic          pop;
  logic          push;

  assign out_valid = (level != '0);
  assign push_req  = in_valid && (in_ascii != ASCII_NUL);
  assign pop       = out_valid && out_ready;
  // a full FIFO still takes a code if the head leaves this cycle
  assign push      = push_req && ((level < FULL) || pop);
  assign out_data  = out_valid ? rdata : ASCII_NUL;

  kbd_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_ascii),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      key_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        key_count <= key_count + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      // a drop in the same cycle beats the clear
      if (push_req && !push)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_kbd_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] key_count;

  int vecs = 0;
  int errs = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  int         m_cnt;

  always #5 clk = ~clk;

  kbd_fifo #(.DEPTH(8), .AW(3), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ascii  (in_ascii),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .key_count (key_count)
  );

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic       r;
    logic       c;
    int         lvl;
    logic       ov;
    logic [7:0] d;
    logic       of;
    int         cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", 32'(out_data),
        32'(q.size() != 0 ? q[0] : 8'h00));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("key_count", 32'(key_count), 32'(m_cnt));
  endtask

  task automatic step(input logic v, input logic [7:0] a,
                      input logic r, input logic c);
    bit p_pop, p_req, p_push;
    in_valid  = v;
    in_ascii  = a;
    out_ready = r;
    clr_ovf   = c;
    p_pop  = (q.size() != 0) && r;
    p_req  = v && (a != 8'h00);
    p_push = p_req && (q.size() < 8 || p_pop);
    @(posedge clk);
    #1;
    if (p_pop) void'(q.pop_front());
    if (p_push) q.push_back(a);
    if (p_req && !p_push) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (p_push) m_cnt = (m_cnt + 1) % 256;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    model_cmp();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_ascii  = 8'h00;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(key_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 8'h71, 0, 0, 1, 1, 8'h71, 0, 1};
    tbl[1] = '{1, 8'h77, 0, 0, 2, 1, 8'h71, 0, 2};
    tbl[2] = '{1, 8'h65, 0, 0, 3, 1, 8'h71, 0, 3};
    tbl[3] = '{1, 8'h00, 0, 0, 3, 1, 8'h71, 0, 3};
    tbl[4] = '{0, 8'h00, 1, 0, 2, 1, 8'h77, 0, 3};
    tbl[5] = '{0, 8'h00, 1, 0, 1, 1, 8'h65, 0, 3};
    tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3};
    tbl[7] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3};
    tbl[8] = '{1, 8'h42, 1, 0, 1, 1, 8'h42, 0, 4};
    tbl[9] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 4};

    do_reset();
    step(0, 8'h00, 0, 0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].r, tbl[i].c);
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ov));
      chk("tbl_data", 32'(out_data), 32'(tbl[i].d));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].of));
      chk("tbl_cnt", 32'(key_count), 32'(tbl[i].cnt));
    end

    // full and overflow
    do_reset();
    for (int i = 0; i < 9; i++)
      step(1, 8'(8'h61 + i), 0, 0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_cnt", 32'(key_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", 32'(out_data), 32'(8'h61 + i));
      step(0, 8'h00, 1, 0);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    step(0, 8'h00, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // drop and clear together: set wins
    for (int i = 0; i < 8; i++)
      step(1, 8'(8'h61 + i), 0, 0);
    step(1, 8'h70, 0, 1);
    chk("set_wins", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("clr2", 32'(overflow), 32'd0);

    // full with simultaneous push and pop
    chk("sp_head", 32'(out_data), 32'h61);
    step(1, 8'h7a, 1, 0);
    chk("sp_level", 32'(level), 32'd8);
    chk("sp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++)
      step(0, 8'h00, 1, 0);
    chk("sp_tail", 32'(out_data), 32'h7a);
    step(0, 8'h00, 1, 0);
    chk("sp_empty", 32'(level), 32'd0);

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++)
      step(1, 8'(1 + (i % 255)), 1, 0);
    chk("cnt_wrap", 32'(key_count), 32'd0);

    // asynchronous reset mid-drain
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++)
      step(1, 8'(8'h30 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("pre_rst_level", 32'(level), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 1)), a,
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule

// File: doc/kbd_fifo.md
Name: kbd_fifo

Overview:
- Downstream of the PS/2 keyboard receiver.
- Captures each single-cycle (in_valid, in_ascii) pulse into a circular FIFO and presents the codes to a consumer through a valid/ready handshake; typical consumers are the seven-segment/VGA terminal logic.
- Discards unmapped keys (ASCII 0x00).
- Keeps a sticky overflow flag and a wrapping total-keystroke counter for display.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2
AW, 3, pointer width, equal to log2(DEPTH)
CNT_W, 8, width of the keystroke counter

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  single-cycle strobe from the PS/2 receiver
in_ascii  input  8  ASCII code, qualified by in_valid
out_valid  output  1  FIFO non-empty; out_data is valid
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  8  ASCII code at the FIFO head
level  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a code was dropped because the FIFO was full
clr_ovf  input  1  synchronous clear of overflow
key_count  output  CNT_W  number of accepted (pushed) codes, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, overflow=0, key_count=0, out_data=0x00. Storage array contents are not reset.
- Push request: push_req = in_valid && (in_ascii != 0x00). A strobe carrying 0x00 is ignored and changes no state.
- Pop: pop = out_valid && out_ready. When out_valid=0, out_ready is ignored.
- Push accept: push = push_req && (level < DEPTH || pop). A full FIFO that pops in the same cycle still accepts the push.
- Accepted push: mem[wr_ptr] <= in_ascii; wr_ptr increments modulo DEPTH; key_count increments with modulo wrap.
- Dropped push: push_req && !push sets overflow=1. Data and pointers are unchanged.
- Overflow clear: clr_ovf=1 clears overflow on the next edge. If a drop happens in the same cycle, set wins and overflow stays 1.
- Level update:
  - level += 1 on push only.
  - level -= 1 on pop only.
  - level is unchanged on push and pop together, or on neither.
- Outputs are combinational from registers:
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr] when level != 0, else 0x00.
- Latency: code accepted at edge N gives out_valid=1 after edge N, so it is visible in cycle N+1. There is no bypass from in_ascii to out_data.
- Empty FIFO with a simultaneous push: the pop is not possible (out_valid=0); the push is accepted normally.
- Ordering: strict FIFO. Pointer wrap from DEPTH-1 to 0 is seamless.
- Reset asserted mid-operation: all buffered codes are lost; outputs return to their reset values immediately (asynchronously).
- in_valid held high for multiple cycles: each cycle counts as a separate push. The upstream receiver guarantees single-cycle pulses.
- Implementation limits: no latches; storage is a register array. Estimated RTL size 120-200 lines including the sub-module.

Decomposition:
- Shared package kbd_pkg:
  - ASCII_NUL=8'h00, ASCII_CR=8'h0d, ASCII_BS=8'h08.
  - Default DEPTH and CNT_W.
- One natural sub-module, kbd_fifo_mem: DEPTH x 8 register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, level, flag and counter logic stays in kbd_fifo.

Test Plan:
1. Reset then idle: reset_n low for 2 cycles, then high with no input -> out_valid=0, level=0, overflow=0, key_count=0, out_data=0x00.
2. In-order delivery: push 0x71, 0x77, 0x65 with out_ready=0 -> level=3. Then set out_ready=1 -> out_data sequence 0x71, 0x77, 0x65 on consecutive cycles; level ends at 0; key_count=3.
3. Null filter: in_valid with in_ascii=0x00 -> level, key_count and overflow all unchanged.
4. Full and overflow: push 9 codes (0x61..0x69) into DEPTH=8 with out_ready=0.
   - Expected: level=8, overflow=1, key_count=8; draining returns 0x61..0x68.
   - Then pulse clr_ovf -> overflow=0.
5. Full with simultaneous push and pop: FIFO full with head 0x61; push 0x7a while out_ready=1.
   - Expected: level stays 8, overflow stays 0, 0x7a becomes the tail; after a full drain the last code is 0x7a.
6. Counter wrap and asynchronous reset: accept 256 codes with out_ready=1 -> key_count wraps to 0.
   - Then assert reset_n mid-drain with level=4 -> level=0 and out_valid=0 before the next clock edge.
